// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: per-port req/we/addr/wdata in,
// rdy/gnt/rdata back. Master = requesters, slave = arbiter.
interface mem_arbiter_if #(
  parameter int NPORTS = 3,
  parameter int AW     = 16,
  parameter int DW     = 16
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] wdata;
  logic [NPORTS-1:0]    rdy;
  logic [NPORTS-1:0]    gnt;
  logic [DW-1:0]        rdata;

  modport master (
    output req, we, addr, wdata,
    input  rdy, gnt, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdy, gnt, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-port arbiter for one single-ported synchronous SRAM.
// Fixed or round-robin grant, optional port-0 priority, RD_LAT-deep completion pipe.
module mem_arbiter #(
  parameter int NPORTS   = 3,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 1,
  parameter int P0_PRIO  = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int L  = RD_LAT - 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          gvld;
  logic          rr_hit;
  logic          g_we;
  int            j;

  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] prd;
  logic [PW-1:0]     pidx [RD_LAT];
  logic [DW-1:0]     rd_q;
  logic              rd_hit;

  // Scan downwards so the lowest index (or the one nearest ptr) wins last.
  always_comb begin
    gvld   = 1'b0;
    gidx   = '0;
    rr_hit = 1'b0;
    j      = 0;
    if (P0_PRIO != 0 && bus.req[0]) begin
      gvld = 1'b1;
    end else if (ARB_MODE == 0 || NPORTS == 1) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (bus.req[i]) begin
          gvld = 1'b1;
          gidx = PW'(i);
        end
      end
    end else begin
      for (int k = NPORTS - 1; k >= 0; k--) begin
        j = (int'(ptr) + k) % NPORTS;
        if (bus.req[j]) begin
          gvld   = 1'b1;
          rr_hit = 1'b1;
          gidx   = PW'(j);
        end
      end
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (gvld) bus.gnt[gidx] = 1'b1;
  end

  always_comb begin
    g_we      = bus.we[gidx];
    mem_we    = gvld & g_we;
    mem_re    = gvld & ~g_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gvld) begin
      mem_addr  = bus.addr[int'(gidx)*AW +: AW];
      mem_wdata = bus.wdata[int'(gidx)*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (rr_hit) begin
      ptr <= (int'(gidx) == NPORTS - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv  <= '0;
      prd <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
    end else begin
      pv[0]   <= gvld;
      prd[0]  <= gvld & ~g_we;
      pidx[0] <= gidx;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]   <= pv[i-1];
        prd[i]  <= prd[i-1];
        pidx[i] <= pidx[i-1];
      end
    end
  end

  always_comb begin
    bus.rdy = '0;
    if (pv[L]) bus.rdy[pidx[L]] = 1'b1;
  end

  // SRAM data lands in the completion cycle; pass it through, then hold it.
  assign rd_hit    = pv[L] & prd[L];
  assign bus.rdata = rd_hit ? mem_rdata : rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_hit) begin
      rd_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four configurations run side by side, each with an
// SRAM model, directed literal checks and random requesters vs a queue model.
module tb_mem_arbiter;
  localparam int N    = 3;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int NCFG = 4;
  localparam int NRND = 2000;

  localparam int CFG_RL  [NCFG] = '{1, 2, 1, 3};
  localparam int CFG_ARB [NCFG] = '{1, 1, 0, 0};
  localparam int CFG_P0  [NCFG] = '{1, 0, 0, 1};

  localparam logic [2:0] EXP_ALL [NCFG][6] = '{
    '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001},
    '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100},
    '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001},
    '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001}
  };
  localparam logic [2:0] EXP_HI [NCFG][4] = '{
    '{3'b010, 3'b100, 3'b010, 3'b100},
    '{3'b010, 3'b100, 3'b010, 3'b100},
    '{3'b010, 3'b010, 3'b010, 3'b010},
    '{3'b010, 3'b010, 3'b010, 3'b010}
  };

  typedef struct {
    int        due;
    int        port;
    bit        rd;
    bit [15:0] data;
  } cpl_t;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  wire [NCFG-1:0] done_v;

  task automatic chk(input int cfg, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL cfg%0d %s: got %h, want %h at %0t",
               cfg, nm, act, exp, $time);
    end
  endtask

  function automatic bit [15:0] init_val(input int a);
    return 16'h00A0 + 16'(a);
  endfunction

  function automatic int pick(input logic [2:0] rq, input int ptr,
                              input int arb, input int p0);
    int i;
    if (p0 != 0 && rq[0]) return 0;
    for (int k = 0; k < N; k++) begin
      i = (arb != 0) ? (ptr + k) % N : k;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  for (genvar c = 0; c < NCFG; c++) begin : cfg
    localparam int RL = CFG_RL[c];

    mem_arbiter_if #(.NPORTS(N), .AW(AW), .DW(DW)) bus ();

    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    bit            fin = 1'b0;

    assign done_v[c] = fin;

    mem_arbiter #(
      .NPORTS(N), .AW(AW), .DW(DW), .RD_LAT(RL),
      .ARB_MODE(CFG_ARB[c]), .P0_PRIO(CFG_P0[c])
    ) dut (
      .clk       (clk),
      .reset     (rst),
      .bus       (bus),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata)
    );

    // SRAM: unwritten words read back as init_val.
    bit [15:0] sram [16];
    bit [15:0] wr;
    bit [15:0] rp [3];
    assign mem_rdata = rp[RL-1];

    always @(posedge clk) begin
      if (mem_we) begin
        sram[mem_addr[3:0]] <= mem_wdata;
        wr[mem_addr[3:0]]   <= 1'b1;
      end
      if (mem_re)
        rp[0] <= wr[mem_addr[3:0]] ? sram[mem_addr[3:0]]
                                   : init_val(int'(mem_addr[3:0]));
      rp[1] <= rp[0];
      rp[2] <= rp[1];
    end

    // Reference model: grant rule, pointer, completion queue, memory image.
    cpl_t      q [$];
    int        ptr_m = 0;
    int        cyc = 0;
    bit [15:0] held = 0;
    bit [15:0] mm [16];
    bit [15:0] mmw = 0;

    always @(negedge clk) begin : model
      logic [2:0]  er;
      logic [15:0] erd;
      logic [2:0]  eg;
      logic [15:0] ea;
      logic [15:0] ewd;
      logic        ewe;
      logic        ere;
      int          g;
      cpl_t        e;
      if (rst) begin
        q.delete();
        ptr_m = 0;
        held  = 0;
      end
      er  = 0;
      erd = held;
      if (!rst && q.size() > 0 && q[0].due == cyc) begin
        er[q[0].port] = 1'b1;
        if (q[0].rd) begin
          erd  = q[0].data;
          held = q[0].data;
        end
        void'(q.pop_front());
      end
      g   = pick(bus.req, ptr_m, CFG_ARB[c], CFG_P0[c]);
      eg  = 0;
      ea  = 0;
      ewd = 0;
      ewe = 0;
      ere = 0;
      if (g >= 0) begin
        eg[g] = 1'b1;
        ea    = bus.addr[g*AW +: AW];
        ewd   = bus.wdata[g*DW +: DW];
        ewe   = bus.we[g];
        ere   = !bus.we[g];
      end
      chk(c, "gnt", bus.gnt, eg);
      chk(c, "mem_we", mem_we, ewe);
      chk(c, "mem_re", mem_re, ere);
      chk(c, "mem_addr", mem_addr, ea);
      chk(c, "mem_wdata", mem_wdata, ewd);
      chk(c, "rdy", bus.rdy, er);
      chk(c, "rdata", bus.rdata, erd);
      if (!rst && g >= 0) begin
        e.due  = cyc + RL;
        e.port = g;
        e.rd   = ere;
        e.data = mmw[ea[3:0]] ? mm[ea[3:0]] : init_val(int'(ea[3:0]));
        if (ewe) begin
          mm[ea[3:0]]  = ewd;
          mmw[ea[3:0]] = 1'b1;
        end
        q.push_back(e);
        if (CFG_ARB[c] != 0 && !(CFG_P0[c] != 0 && bus.req[0]))
          ptr_m = (g + 1) % N;
      end
      cyc++;
    end

    logic [2:0] pg;
    always @(negedge clk) pg <= bus.gnt;

    bit [2:0] pend;
    bit [2:0] outs;

    initial begin
      rst       = 1'b1;
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk(c, "reset_rdy", bus.rdy, 3'b000);
      chk(c, "reset_rdata", bus.rdata, 16'h0000);

      // Lone read of address 3 by port 1.
      @(posedge clk); #1;
      bus.req = 3'b010;
      bus.addr[AW +: AW] = 16'h0003;
      @(negedge clk);
      chk(c, "lat_gnt", bus.gnt, 3'b010);
      chk(c, "lat_re", mem_re, 1'b1);
      @(posedge clk); #1;
      bus.req = 3'b000;
      for (int i = 1; i <= RL; i++) begin
        if (i > 1) @(posedge clk);
        @(negedge clk);
        chk(c, "lat_rdy", bus.rdy, (i == RL) ? 3'b010 : 3'b000);
        if (i == RL) chk(c, "lat_rdata", bus.rdata, 16'h00A3);
      end

      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;

      // Contention: all three, then ports 1 and 2.
      bus.req = 3'b111;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk(c, "all_gnt", bus.gnt, EXP_ALL[c][i]);
        @(posedge clk); #1;
      end
      bus.req = 3'b110;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk(c, "hi_gnt", bus.gnt, EXP_HI[c][i]);
        @(posedge clk); #1;
      end
      bus.req = 3'b000;
      repeat (4) @(posedge clk);
      #1;

      // Reset while a port-1 read is in flight.
      bus.req = 3'b010;
      bus.addr[AW +: AW] = 16'h0005;
      @(negedge clk);
      chk(c, "mid_gnt", bus.gnt, 3'b010);
      @(posedge clk); #1;
      bus.req = 3'b000;
      rst = 1'b1;
      @(negedge clk);
      chk(c, "mid_rdy", bus.rdy, 3'b000);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 2; i <= 4; i++) begin
        @(negedge clk);
        chk(c, "mid_rdy", bus.rdy, 3'b000);
        @(posedge clk); #1;
      end
      bus.req = 3'b111;
      @(negedge clk);
      chk(c, "post_rst_gnt", bus.gnt, 3'b001);
      @(posedge clk); #1;
      bus.req = 3'b000;
      repeat (4) @(posedge clk);

      // Random requesters obeying the hold-until-granted contract.
      pend = '0;
      outs = '0;
      for (int t = 0; t < NRND; t++) begin
        @(posedge clk); #1;
        for (int p = 0; p < N; p++) begin
          if (pend[p] && pg[p]) begin
            pend[p] = 1'b0;
            outs[p] = 1'b1;
          end
          if (outs[p] && bus.rdy[p]) outs[p] = 1'b0;
          if (!pend[p] && !outs[p] && $urandom_range(0, 3) != 0) begin
            pend[p]                = 1'b1;
            bus.we[p]              = 1'($urandom_range(0, 1));
            bus.addr[p*AW +: AW]   = 16'($urandom_range(0, 15));
            bus.wdata[p*DW +: DW]  = 16'($urandom);
          end
          bus.req[p] = pend[p];
        end
      end
      @(posedge clk); #1;
      bus.req = 3'b000;
      repeat (RL + 1) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      @(posedge clk);
      if (&done_v) break;
    end
    if (!(&done_v)) begin
      nchk++;
      nfail++;
      $display("FAIL timeout: done %b, want %b", done_v, {NCFG{1'b1}});
    end
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
